hs32_user_project_wrapper: RTL and testbench



---
 rtl/hs32_user_project_wrapper.sv | 239 +++++++++++++++++++++++
 tb/tb_hs32_user_project_wrapper.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_user_project_wrapper.sv
// Caravel user-area wrapper: a small multi-cycle HS32 subset core sharing a program RAM
// with the Wishbone host port, plus a vectored interrupt table on the core's data side.
//
// state   | meaning
// S_FETCH | issue synchronous RAM read at PC (fault if PC is past the end of RAM)
// S_EXEC  | decode fetched word; ALU, branch, INT and RETI complete here
// S_MEM   | LDR/STR data access to RAM or vector table
// S_FAULT | terminal until core reset
module hs32_user_project_wrapper #(
   parameter int MPRJ_IO_PADS = 38,
   parameter int MEM_WORDS    = 256
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_dat_i,
   input  logic [31:0]              wbs_adr_i,
   output logic                     wbs_ack_o,
   output logic [31:0]              wbs_dat_o,
   input  logic [127:0]             la_data_in,
   output logic [127:0]             la_data_out,
   input  logic [127:0]             la_oen,
   input  logic [MPRJ_IO_PADS-1:0]  io_in,
   output logic [MPRJ_IO_PADS-1:0]  io_out,
   output logic [MPRJ_IO_PADS-1:0]  io_oeb,
   inout  wire  [MPRJ_IO_PADS-10:0] analog_io,
   input  logic                     user_clock2
);

   localparam int          AW        = $clog2(MEM_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_FAULT} state_t;

   logic core_rst, core_en;
   assign core_rst = wb_rst_i | la_data_in[0];
   assign core_en  = la_data_in[1] & ~core_rst;

   assign io_out = '0;
   assign io_oeb = '1;

   logic unused_ok;

   logic [31:0]   mem [MEM_WORDS];
   logic [31:0]   core_q;
   logic          wb_req, ack_done;
   logic [AW-1:0] wb_idx;

   state_t        state, state_nx;
   logic [31:0]   pc, pc_nx, ea, ea_nx;
   logic [31:0]   regs [16];
   logic [31:0]   vtab [16];
   logic          irq, irq_nx;
   logic [7:0]    ir_op, ir_op_nx;
   logic [3:0]    ir_rd, ir_rd_nx;
   logic          rf_we, vt_we, ram_we, ram_re;
   logic [3:0]    rf_wa;
   logic [31:0]   rf_wd;
   logic [AW-1:0] ram_ra;

   logic [7:0]    op;
   logic [3:0]    rd, rm, ea_slot;
   logic [15:0]   imm;
   logic [31:0]   imm_z, imm_s, ea_c, vt_rd;
   logic          ea_vt;

   assign unused_ok = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0], la_data_in[127:2], la_oen,
                        io_in, analog_io, user_clock2, ea[1:0]};

   assign op    = core_q[31:24];
   assign rd    = core_q[23:20];
   assign rm    = core_q[19:16];
   assign imm   = core_q[15:0];
   assign imm_z = {16'd0, imm};
   assign imm_s = {{16{imm[15]}}, imm};
   assign ea_c  = regs[rm] + imm_z;

   // Slot 0 (0xFF00) holds no entry; vtab[15] is never written so INT 15 always faults.
   assign ea_vt   = (ea[31:6] == 26'h3FC);
   assign ea_slot = ea[5:2];
   assign vt_rd   = (ea_slot == 4'd0) ? '0 : vtab[ea_slot - 4'd1];

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      irq_nx   = irq;
      ea_nx    = ea;
      ir_op_nx = ir_op;
      ir_rd_nx = ir_rd;
      rf_we    = 1'b0;
      rf_wa    = rd;
      rf_wd    = '0;
      vt_we    = 1'b0;
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      ram_ra   = pc[AW+1:2];
      case (state)
         S_FETCH: begin
            if (pc >= MEM_BYTES) begin
               state_nx = S_FAULT;
            end else begin
               ram_re   = 1'b1;
               state_nx = S_EXEC;
            end
         end
         S_EXEC: begin
            ir_op_nx = op;
            ir_rd_nx = rd;
            ea_nx    = ea_c;
            state_nx = S_FETCH;
            pc_nx    = pc + 32'd4;
            case (op)
               8'h24: begin
                  rf_we = 1'b1;
                  rf_wd = imm_z;
               end
               8'h44: begin
                  rf_we = 1'b1;
                  rf_wd = ea_c;
               end
               8'h14: begin
                  ram_re   = 1'b1;
                  ram_ra   = ea_c[AW+1:2];
                  state_nx = S_MEM;
                  pc_nx    = pc;
               end
               8'h34: begin
                  state_nx = S_MEM;
                  pc_nx    = pc;
               end
               8'h90: begin
                  if (vtab[imm[3:0]][0] && !irq) begin
                     rf_we  = 1'b1;
                     rf_wa  = 4'd14;
                     rf_wd  = pc;
                     irq_nx = 1'b1;
                     pc_nx  = {vtab[imm[3:0]][31:1], 1'b0};
                  end else begin
                     state_nx = S_FAULT;
                     pc_nx    = pc;
                  end
               end
               8'h50: pc_nx = pc + imm_s;
               8'h5F: begin
                  if (irq) begin
                     pc_nx  = regs[14];
                     irq_nx = 1'b0;
                  end else begin
                     state_nx = S_FAULT;
                     pc_nx    = pc;
                  end
               end
               default: begin
                  state_nx = S_FAULT;
                  pc_nx    = pc;
               end
            endcase
         end
         S_MEM: begin
            state_nx = S_FETCH;
            pc_nx    = pc + 32'd4;
            if (ir_op == 8'h14) begin
               rf_we = 1'b1;
               rf_wa = ir_rd;
               rf_wd = ea_vt ? vt_rd : core_q;
            end else if (ea_vt) begin
               vt_we = (ea_slot != 4'd0);
            end else begin
               ram_we = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Dropping la[1] freezes the core exactly where it is, including core_q.
   always_ff @(posedge wb_clk_i) begin
      if (core_rst) begin
         state <= S_FETCH;
         pc    <= '0;
         irq   <= 1'b0;
         ea    <= '0;
         ir_op <= '0;
         ir_rd <= '0;
         for (int i = 0; i < 16; i++) begin
            regs[i] <= '0;
            vtab[i] <= '0;
         end
      end else if (core_en) begin
         state <= state_nx;
         pc    <= pc_nx;
         irq   <= irq_nx;
         ea    <= ea_nx;
         ir_op <= ir_op_nx;
         ir_rd <= ir_rd_nx;
         if (rf_we) regs[rf_wa] <= rf_wd;
         if (vt_we) vtab[ea_slot - 4'd1] <= regs[ir_rd];
      end
   end

   assign wb_req = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & ~ack_done & ~wb_rst_i;
   assign wb_idx = wbs_adr_i[AW+1:2];

   always_ff @(posedge wb_clk_i) begin
      if (core_en && ram_we) begin
         mem[ea[AW+1:2]] <= regs[ir_rd];
      end else if (wb_req && wbs_we_i && !la_data_in[1]) begin
         for (int b = 0; b < 4; b++)
            if (wbs_sel_i[b]) mem[wb_idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
      if (core_en && ram_re) core_q <= mem[ram_ra];
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         ack_done  <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= wb_req;
         ack_done  <= wbs_cyc_i & (ack_done | wbs_ack_o);
         wbs_dat_o <= (wb_req && !wbs_we_i && !la_data_in[1]) ? mem[wb_idx] : '0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         la_data_out <= '0;
      end else begin
         la_data_out <= {regs[5], regs[4], pc, 30'd0,
                         core_en && (state != S_FAULT), state == S_FAULT};
      end
   end

endmodule

// File: tb/tb_hs32_user_project_wrapper.sv
// Bench for hs32_user_project_wrapper: directed programs plus random programs checked
// against an instruction-level model of the core and a shadow copy of the RAM.
module tb_hs32_user_project_wrapper;
   localparam int PADS = 38;

   logic             clk = 1'b0;
   logic             rst, stb, cyc, we, ack, user_clock2;
   logic [3:0]       sel;
   logic [31:0]      dat_i, adr, dat_o;
   logic [127:0]     la_in, la_out, la_oen;
   logic [PADS-1:0]  io_in, io_out, io_oeb;
   wire  [PADS-10:0] analog_unused;

   always #5 clk = ~clk;

   hs32_user_project_wrapper #(.MPRJ_IO_PADS(PADS), .MEM_WORDS(256)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .la_data_in(la_in), .la_data_out(la_out), .la_oen(la_oen), .io_in(io_in),
      .io_out(io_out), .io_oeb(io_oeb), .analog_io(analog_unused), .user_clock2(user_clock2)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_mem [256];
   logic [31:0] m_r [16];
   logic [31:0] m_tbl [15];
   logic [31:0] m_pc;
   bit          m_irq, m_fault;
   logic [31:0] prog [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_load(input logic [31:0] a);
      int slot;
      if (a >= 32'hFF00 && a <= 32'hFF3F) begin
         slot = int'((a - 32'hFF00) >> 2);
         return (slot == 0) ? 32'd0 : m_tbl[slot-1];
      end
      return m_mem[a[9:2]];
   endfunction

   task automatic m_store(input logic [31:0] a, input logic [31:0] d);
      int slot;
      if (a >= 32'hFF00 && a <= 32'hFF3F) begin
         slot = int'((a - 32'hFF00) >> 2);
         if (slot != 0) m_tbl[slot-1] = d;
      end else begin
         m_mem[a[9:2]] = d;
      end
   endtask

   // Executes from a fresh core reset until a spin (B +0) or a fault.
   task automatic model_run();
      logic [31:0] ins, a, imm;
      int          rd, rm, n;
      m_pc = 0; m_irq = 0; m_fault = 0;
      for (int i = 0; i < 16; i++) m_r[i] = 0;
      for (int i = 0; i < 15; i++) m_tbl[i] = 0;
      for (int s = 0; s < 500; s++) begin
         if (m_pc >= 32'd1024) begin m_fault = 1; break; end
         ins = m_mem[m_pc[9:2]];
         rd  = int'(ins[23:20]);
         rm  = int'(ins[19:16]);
         imm = {16'd0, ins[15:0]};
         a   = m_r[rm] + imm;
         case (ins[31:24])
            8'h24: begin m_r[rd] = imm; m_pc += 4; end
            8'h44: begin m_r[rd] = a; m_pc += 4; end
            8'h14: begin m_r[rd] = m_load(a); m_pc += 4; end
            8'h34: begin m_store(a, m_r[rd]); m_pc += 4; end
            8'h90: begin
               n = int'(ins[3:0]);
               if (n < 15 && m_tbl[n][0] && !m_irq) begin
                  m_r[14] = m_pc; m_irq = 1; m_pc = m_tbl[n] & ~32'd1;
               end else begin
                  m_fault = 1; break;
               end
            end
            8'h50: begin
               if (ins[15:0] == 16'd0) break;
               m_pc = m_pc + {{16{ins[15]}}, ins[15:0]};
            end
            8'h5F: begin
               if (m_irq) begin m_pc = m_r[14]; m_irq = 0; end
               else begin m_fault = 1; break; end
            end
            default: begin m_fault = 1; break; end
         endcase
      end
   endtask

   task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdat, output int acks);
      acks = 0; rdat = '0;
      @(negedge clk);
      stb = 1; cyc = 1; we = w; adr = a; dat_i = d; sel = s;
      repeat (3) begin
         @(posedge clk); #1;
         if (ack) begin acks++; rdat = dat_o; end
      end
      @(negedge clk);
      stb = 0; cyc = 0; we = 0;
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r; int acks;
      wb_xfer(1'b1, a, d, s, r, acks);
      check("wr_ack", 32'(acks), 32'd1);
      if (!la_in[1])
         for (int b = 0; b < 4; b++) if (s[b]) m_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic wb_read_check(input string tag, input logic [31:0] a);
      logic [31:0] r; int acks;
      wb_xfer(1'b0, a, 32'd0, 4'hF, r, acks);
      check({tag, ".ack"}, 32'(acks), 32'd1);
      check(tag, r, la_in[1] ? 32'd0 : m_mem[a[9:2]]);
   endtask

   task automatic load_prog();
      la_in[1:0] = 2'b00;
      for (int i = 0; i < prog.size(); i++) wb_write(32'(4 * i), prog[i], 4'hF);
   endtask

   task automatic run_core(input int active, input bit jitter);
      int n = 0;
      @(negedge clk); la_in[1:0] = 2'b11;
      repeat (2) @(negedge clk);
      for (int g = 0; g < 20 * active && n < active; g++) begin
         if (jitter && $urandom_range(3) == 0) la_in[1:0] = 2'b00;
         else begin la_in[1:0] = 2'b10; n++; end
         @(negedge clk);
      end
      la_in[1:0] = 2'b10;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_core(input string tag);
      check({tag, ".fault"}, 32'(la_out[0]), 32'(m_fault));
      check({tag, ".pc"}, la_out[63:32], m_pc);
      check({tag, ".r4"}, la_out[95:64], m_r[4]);
      check({tag, ".r5"}, la_out[127:96], m_r[5]);
   endtask

   initial begin
      logic [3:0]  rdf, rmf;
      logic [15:0] immf;
      logic [5:0]  off;
      int          k;
      rst = 1; stb = 0; cyc = 0; we = 0; sel = 0; dat_i = 0; adr = 0;
      la_in = '0; la_oen = '1; io_in = '0; user_clock2 = 0;
      repeat (3) @(negedge clk);
      check("rst.ack", 32'(ack), 32'd0);
      check("rst.dat_o", dat_o, 32'd0);
      check("rst.la0", la_out[31:0], 32'd0);
      check("rst.la1", la_out[63:32], 32'd0);
      check("rst.la2", la_out[95:64], 32'd0);
      check("rst.la3", la_out[127:96], 32'd0);
      check("io_out", 32'(|io_out), 32'd0);
      check("io_oeb", 32'(&io_oeb), 32'd1);
      rst = 0;

      // Byte-select write, alias and low-address-bit behaviour
      wb_write(32'h40, 32'hFFFF_FFFF, 4'hF);
      wb_write(32'h40, 32'h1234_5678, 4'b0011);
      wb_read_check("sel_rd", 32'h40);
      check("sel_rd.const", m_mem[16], 32'hFFFF_5678);
      wb_read_check("alias_rd", 32'h443);
      for (int i = 0; i < 64; i++) wb_write(32'h200 + 32'(4 * i), $urandom, 4'hF);
      wb_write(32'h80, 32'hA5A5_0F0F, 4'hF);

      // Interrupt round trip
      prog = '{32'h2400FF00, 32'h24100019, 32'h34100010, 32'h90000003, 32'h2450CAFE,
               32'h50000000, 32'h2440C0DE, 32'h44EE0004, 32'h5F000000};
      load_prog();
      run_core(60, 1'b0);
      model_run();
      check("p1.r4", la_out[95:64], 32'h0000C0DE);
      check("p1.r5", la_out[127:96], 32'h0000CAFE);
      check("p1.pc", la_out[63:32], 32'h14);
      check("p1.fault", 32'(la_out[0]), 32'd0);
      check("p1.run", 32'(la_out[1]), 32'd1);

      // Host port while core owns RAM
      wb_write(32'h80, 32'hDEAD_BEEF, 4'hF);
      wb_read_check("run_rd", 32'h80);
      @(negedge clk); la_in[1:0] = 2'b00;
      wb_read_check("kept_rd", 32'h80);

      // Whole-block reset mid-run keeps RAM
      @(negedge clk); la_in[1:0] = 2'b10;
      repeat (5) @(negedge clk);
      rst = 1;
      repeat (2) @(negedge clk);
      check("wbrst.la_lo", la_out[63:0] == 64'd0 ? 32'd1 : 32'd0, 32'd1);
      check("wbrst.la_hi", la_out[127:64] == 64'd0 ? 32'd1 : 32'd0, 32'd1);
      rst = 0;
      repeat (60) @(negedge clk);
      check_core("p1_rerun");

      // Store then load through the same address
      prog = '{32'h2400CAFE, 32'h24100005, 32'h34010004, 32'h14210004, 32'h50000000};
      load_prog();
      run_core(40, 1'b0);
      model_run();
      check("p2.pc", la_out[63:32], 32'h10);
      check("p2.fault", 32'(la_out[0]), 32'd0);
      @(negedge clk); la_in[1:0] = 2'b00;
      wb_read_check("p2.mem8", 32'h8);
      check("p2.mem8.const", m_mem[2], 32'h0000CAFE);

      // INT with an empty vector table
      prog = '{32'h90000003};
      load_prog();
      run_core(20, 1'b0);
      model_run();
      check("int_empty.fault", 32'(la_out[0]), 32'd1);
      check("int_empty.pc", la_out[63:32], 32'h0);

      // Unknown opcode, then core reset clears it
      prog = '{32'hEE000000};
      load_prog();
      run_core(20, 1'b0);
      check("badop.fault", 32'(la_out[0]), 32'd1);
      @(negedge clk); la_in[1:0] = 2'b11;
      repeat (3) @(negedge clk);
      check("badop.clr_fault", 32'(la_out[0]), 32'd0);
      check("badop.clr_pc", la_out[63:32], 32'h0);
      @(negedge clk); la_in[1:0] = 2'b00;

      // Random straight-line programs with random run/freeze toggling
      for (int t = 0; t < 8; t++) begin
         prog = '{32'h24F00200};
         k = int'($urandom_range(6, 12));
         for (int i = 0; i < k; i++) begin
            rdf  = $urandom_range(1) ? 4'(4 + $urandom_range(1)) : 4'($urandom_range(14));
            rmf  = 4'($urandom_range(15));
            immf = 16'($urandom);
            off  = 6'($urandom_range(63));
            case ($urandom_range(3))
               0: prog.push_back({8'h24, rdf, rmf, immf});
               1: prog.push_back({8'h44, rdf, rmf, immf});
               2: prog.push_back({8'h34, rdf, 4'hF, 8'h00, off, 2'b00});
               default: prog.push_back({8'h14, rdf, 4'hF, 8'h00, off, 2'b00});
            endcase
         end
         prog.push_back(32'h50000000);
         load_prog();
         run_core(3 * k + 15, 1'b1);
         model_run();
         check_core($sformatf("rand%0d", t));
         @(negedge clk); la_in[1:0] = 2'b00;
         for (int j = 0; j < 3; j++)
            wb_read_check($sformatf("rand%0d.mem", t), 32'h200 + 32'(4 * $urandom_range(63)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
